// File: rtl/regfile_sb_if.sv
// Issue/write-back bus of the register file. The master side (decode/issue and
// write-back) drives addresses, write data and reservations. The slave side
// (the register file) returns read data and busy flags.
interface regfile_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] AddrA;
  logic [AW-1:0] AddrB;
  logic [DW-1:0] DoA;
  logic [DW-1:0] DoB;
  logic          BusyA;
  logic          BusyB;
  logic [AW-1:0] AddrC;
  logic [DW-1:0] DinC;
  logic          wrback;
  logic [AW-1:0] AddrD;
  logic [DW-1:0] DinD;
  logic          wrbackD;
  logic [AW-1:0] RsvAddr;
  logic          RsvEn;

  modport master (
    output AddrA, AddrB, AddrC, DinC, wrback, AddrD, DinD, wrbackD, RsvAddr, RsvEn,
    input  DoA, DoB, BusyA, BusyB
  );

  modport slave (
    input  AddrA, AddrB, AddrC, DinC, wrback, AddrD, DinD, wrbackD, RsvAddr, RsvEn,
    output DoA, DoB, BusyA, BusyB
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with same-cycle write-to-read bypass,
// an optional hardwired zero register and a per-register busy scoreboard.

// One combinational read port. It resolves zero-register, bypass and stored
// state into the data and busy values for its address.
module regfile_sb_rdport #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] stored,
  input  logic          storedBusy,
  input  logic          bypassEn,
  input  logic          wrC,
  input  logic [AW-1:0] addrC,
  input  logic [DW-1:0] dinC,
  input  logic          wrD,
  input  logic [AW-1:0] addrD,
  input  logic [DW-1:0] dinD,
  output logic [DW-1:0] rdData,
  output logic          rdBusy
);
  logic isZero, hitC, hitD;

  assign isZero = (ZERO_REG != 0) && (addr == '0);
  assign hitC   = bypassEn && wrC && (addrC == addr);
  assign hitD   = bypassEn && wrD && (addrD == addr);

  // Port D beats port C, because it also wins the array write when both ports hit.
  // A forwarded write already carries the pending result, so the register is not busy.
  always_comb begin
    rdData = stored;
    rdBusy = storedBusy;
    if (isZero) begin
      rdData = '0;
      rdBusy = 1'b0;
    end else if (hitD) begin
      rdData = dinD;
      rdBusy = 1'b0;
    end else if (hitC) begin
      rdData = dinC;
      rdBusy = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** AW;
  localparam int NRD   = 2;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [DEPTH-1:0]         busy;

  // Effective write and reservation enables. Register 0 is inert when hardwired.
  logic wrC, wrD, rsv;
  assign wrC = bus.wrback  && !((ZERO_REG != 0) && (bus.AddrC   == '0));
  assign wrD = bus.wrbackD && !((ZERO_REG != 0) && (bus.AddrD   == '0));
  assign rsv = bus.RsvEn   && !((ZERO_REG != 0) && (bus.RsvAddr == '0));

  // Array and scoreboard update. The later assignments win: port D over port C,
  // and a new reservation over the clear from a write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      if (wrC) begin
        mem[bus.AddrC]  <= bus.DinC;
        busy[bus.AddrC] <= 1'b0;
      end
      if (wrD) begin
        mem[bus.AddrD]  <= bus.DinD;
        busy[bus.AddrD] <= 1'b0;
      end
      if (rsv) busy[bus.RsvAddr] <= 1'b1;
    end
  end

  logic [NRD-1:0][AW-1:0] rdAddr;
  logic [NRD-1:0][DW-1:0] rdData;
  logic [NRD-1:0]         rdBusy;

  assign rdAddr = {bus.AddrB, bus.AddrA};

  // Bypass is suppressed during reset so the outputs show only stored state.
  generate
    for (genvar g = 0; g < NRD; g++) begin : gRd
      regfile_sb_rdport #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) uRd (
        .addr       (rdAddr[g]),
        .stored     (mem[rdAddr[g]]),
        .storedBusy (busy[rdAddr[g]]),
        .bypassEn   (!rst),
        .wrC        (bus.wrback),
        .addrC      (bus.AddrC),
        .dinC       (bus.DinC),
        .wrD        (bus.wrbackD),
        .addrD      (bus.AddrD),
        .dinD       (bus.DinD),
        .rdData     (rdData[g]),
        .rdBusy     (rdBusy[g])
      );
    end
  endgenerate

  assign bus.DoA   = rdData[0];
  assign bus.DoB   = rdData[1];
  assign bus.BusyA = rdBusy[0];
  assign bus.BusyB = rdBusy[1];
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the 32x32 two-read/one-write register file used by the tinyproc datapath.
- Adds a second write-back port, so ALU and load results can both retire in one cycle.
- Adds same-cycle write-to-read bypass.
- Adds an optional hardwired zero register.
- Adds a per-register busy scoreboard, which the issue stage uses to stall on RAW hazards.
- Sits between decode/issue and the execute and write-back stages.

Parameters:
DW, 32, data width in bits.
AW, 5, address width; depth = 2**AW registers.
ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
AddrA  in  AW  read port A address.
AddrB  in  AW  read port B address.
DoA  out  DW  read port A data (combinational).
DoB  out  DW  read port B data (combinational).
BusyA  out  1  register at AddrA has a pending result.
BusyB  out  1  register at AddrB has a pending result.
AddrC  in  AW  write port C address (ALU write-back).
DinC  in  DW  write port C data.
wrback  in  1  write enable, port C.
AddrD  in  AW  write port D address (load write-back).
DinD  in  DW  write port D data.
wrbackD  in  1  write enable, port D.
RsvAddr  in  AW  destination register being issued.
RsvEn  in  1  mark RsvAddr busy.

Behaviour:
Reset
- On a rising clk with rst=1, all 2**AW data registers are set to 0 and all busy bits to 0.
- Writes and reservations in that cycle are discarded.
- While rst=1, bypass is disabled: DoA/DoB/BusyA/BusyB reflect stored state only.
- After a reset edge, every DoX = 0 and every BusyX = 0.

Write
- Write latency is 1 cycle: data is visible in the array after the rising edge.
- Ports C and D write independently.
- If both are enabled to the same address, port D wins.
- Writes to address 0 are dropped when ZERO_REG=1.

Read and bypass
- Reads are combinational, no clock.
- Priority for DoA, highest first:
  1. ZERO_REG and AddrA==0 -> 0.
  2. wrbackD and AddrD==AddrA -> DinD.
  3. wrback and AddrC==AddrA -> DinC.
  4. Otherwise the array entry.
- DoB follows the same rules using AddrB.
- Both read ports may address the same register; both then return the same value.

Scoreboard
- busy[i] is set at the edge when RsvEn and RsvAddr==i.
- busy[i] is cleared at the edge when a write (port C or D) targets i.
- Reserve and write to the same i in one cycle: busy stays 1, because the new reservation supersedes the old result.
- Reserving 0 has no effect when ZERO_REG=1.
- BusyA = busy[AddrA], except it reads 0 when a same-cycle write targets AddrA (the value is already forwarded).
- BusyB follows the same rule with AddrB.

Arithmetic and widths
- No arithmetic inside the block; data is stored and returned bit-exact at DW bits.
- Negative values are stored as two's complement.

Test Plan:
1. Reset and zero register:
   - Hold rst=1 for one edge, then read all addresses -> DoA=DoB=0, BusyA=BusyB=0.
   - Write r0=0xDEADBEEF via port C -> DoA at AddrA=0 stays 0.
2. Basic write/read:
   - Write DinC=-2540 to r1, then 2550 to r2.
   - Set AddrA=2, AddrB=1 -> DoA=2550, DoB=0xFFFFF614.
   - Write DinC=DoA+DoB=10 to r4; reading r4 -> 10.
3. Bypass:
   - With r3=5, drive wrback=1, AddrC=3, DinC=7, AddrA=3 before the edge -> DoA=7 combinationally.
   - After the edge, with wrback=0 -> DoA=7.
4. Dual-write collision:
   - Same cycle: AddrC=AddrD=6, DinC=11, DinD=22 -> r6=22 after the edge.
   - Pre-edge bypass on AddrA=6 -> DoA=22.
5. Scoreboard:
   - RsvEn on r5 -> BusyA(AddrA=5)=1 next cycle.
   - Write r5 via port D -> BusyA=0 in that cycle (bypass) and after the edge.
   - Reserve and write r5 in the same cycle -> BusyA=1 after the edge.
6. Mid-operation reset:
   - r7 busy and holding 99; assert rst with wrback to r7=1 -> after the edge r7=0, not busy, and the write is discarded.
